// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display blocks: active-low hex font and
// a width helper for counters.
package display_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {a,b,c,d,e,f,g} patterns for nibble values 0..F
   localparam logic [6:0] SEG_HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned clog2_w(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module seg_hex_decoder
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_HEX[nibble];
   end

endmodule

// File: rtl/display_seg_mux.sv
// Time-multiplexed common-anode 7-segment driver with blanking, blink, PWM
// dimming and per-frame snapshot of the displayed value.
module display_seg_mux
   import display_pkg::*;
#(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned SCAN_LIMIT = 50000,
   parameter int unsigned BLINK_DIV  = 25000000,
   parameter int unsigned PWM_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   digit_code,
   input  logic [DIGITS-1:0]     dp_en,
   input  logic [DIGITS-1:0]     blink_en,
   input  logic                  blank_lz,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     display_digit,
   output logic                  frame_done
);

   localparam int unsigned SLOT_W  = clog2_w(SCAN_LIMIT);
   localparam int unsigned IDX_W   = clog2_w(DIGITS);
   localparam int unsigned BLINK_W = clog2_w(BLINK_DIV);
   localparam int unsigned CODE_W  = 4 * DIGITS;

   logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                blink_phase_q, blink_phase_d;
   logic                load_q, load_d;
   logic                wrap_q, wrap_d;

   logic [CODE_W-1:0]   code_sh_q, code_sh_d;
   logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [DIGITS-1:0]   blink_sh_q, blink_sh_d;
   logic                blank_sh_q, blank_sh_d;

   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   display_digit_q, display_digit_d;
   logic                frame_done_q, frame_done_d;

   logic [CODE_W-1:0]   code_src_c;
   logic [DIGITS-1:0]   dp_src_c, blink_src_c, lz_c;
   logic                blank_src_c;
   logic [3:0]          cur_nib_c;
   logic [6:0]          seg_hex_c;
   logic                cur_dp_c, cur_blink_c, cur_lz_c;
   logic                slot_wrap_c, frame_wrap_c, blink_wrap_c;
   logic                pwm_on_c, dark_c, zero_run_c;

   seg_hex_decoder u_dec (
      .nibble (cur_nib_c),
      .seg_c  (seg_hex_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q      <= '0;
         idx_q           <= '0;
         pwm_cnt_q       <= '0;
         blink_cnt_q     <= '0;
         blink_phase_q   <= 1'b0;
         load_q          <= 1'b1;
         wrap_q          <= 1'b0;
         code_sh_q       <= '0;
         dp_sh_q         <= '0;
         blink_sh_q      <= '0;
         blank_sh_q      <= 1'b0;
         seg_q           <= SEG_OFF;
         dp_q            <= 1'b1;
         display_digit_q <= '1;
         frame_done_q    <= 1'b0;
      end else begin
         slot_cnt_q      <= slot_cnt_d;
         idx_q           <= idx_d;
         pwm_cnt_q       <= pwm_cnt_d;
         blink_cnt_q     <= blink_cnt_d;
         blink_phase_q   <= blink_phase_d;
         load_q          <= load_d;
         wrap_q          <= wrap_d;
         code_sh_q       <= code_sh_d;
         dp_sh_q         <= dp_sh_d;
         blink_sh_q      <= blink_sh_d;
         blank_sh_q      <= blank_sh_d;
         seg_q           <= seg_d;
         dp_q            <= dp_d;
         display_digit_q <= display_digit_d;
         frame_done_q    <= frame_done_d;
      end
   end

   always_comb begin
      // Scan, PWM and blink counters
      slot_wrap_c   = (slot_cnt_q == SLOT_W'(SCAN_LIMIT - 1));
      frame_wrap_c  = slot_wrap_c && (idx_q == IDX_W'(DIGITS - 1));
      slot_cnt_d    = slot_wrap_c ? '0 : slot_cnt_q + SLOT_W'(1);
      idx_d         = idx_q;
      if (frame_wrap_c) begin
         idx_d = '0;
      end else if (slot_wrap_c) begin
         idx_d = idx_q + IDX_W'(1);
      end
      pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
      blink_wrap_c  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
      blink_cnt_d   = blink_wrap_c ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_phase_q ^ blink_wrap_c;
      load_d        = 1'b0;
      wrap_d        = frame_wrap_c;
      frame_done_d  = wrap_q;

      // Shadows reload at frame wrap; the first post-reset cycle decodes live inputs
      code_sh_d   = code_sh_q;
      dp_sh_d     = dp_sh_q;
      blink_sh_d  = blink_sh_q;
      blank_sh_d  = blank_sh_q;
      if (load_q || frame_wrap_c) begin
         code_sh_d  = digit_code;
         dp_sh_d    = dp_en;
         blink_sh_d = blink_en;
         blank_sh_d = blank_lz;
      end
      code_src_c  = load_q ? digit_code : code_sh_q;
      dp_src_c    = load_q ? dp_en      : dp_sh_q;
      blink_src_c = load_q ? blink_en   : blink_sh_q;
      blank_src_c = load_q ? blank_lz   : blank_sh_q;

      // A digit is blanked while it and every digit above it are zero
      lz_c       = '0;
      zero_run_c = blank_src_c;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_run_c = zero_run_c && (code_src_c[4*i +: 4] == 4'd0);
         lz_c[i]    = zero_run_c;
      end

      cur_nib_c   = '0;
      cur_dp_c    = 1'b0;
      cur_blink_c = 1'b0;
      cur_lz_c    = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib_c   = code_src_c[4*i +: 4];
            cur_dp_c    = dp_src_c[i];
            cur_blink_c = blink_src_c[i];
            cur_lz_c    = lz_c[i];
         end
      end

      pwm_on_c = (brightness == '1) || (pwm_cnt_q < brightness);
      dark_c   = !pwm_on_c || (blink_phase_q && cur_blink_c);

      display_digit_d = '1;
      seg_d           = SEG_OFF;
      dp_d            = 1'b1;
      if (!dark_c) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            display_digit_d[i] = (idx_q != IDX_W'(i));
         end
         seg_d = cur_lz_c ? SEG_OFF : seg_hex_c;
         dp_d  = !cur_dp_c;
      end
   end

   assign seg           = seg_q;
   assign dp            = dp_q;
   assign display_digit = display_digit_q;
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_display_seg_mux.sv
// Directed self-checking bench for display_seg_mux (4 digits, 4-clk slots, 64-clk blink).
`timescale 1ns/1ps
module tb_display_seg_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digit_code;
   logic [3:0]  dp_en;
   logic [3:0]  blink_en;
   logic        blank_lz;
   logic [3:0]  brightness;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  display_digit;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   // Hand-entered active-low font, 0..F
   logic [6:0] seg_tb [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

   display_seg_mux #(
      .DIGITS     (4),
      .SCAN_LIMIT (4),
      .BLINK_DIV  (64),
      .PWM_BITS   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .digit_code    (digit_code),
      .dp_en         (dp_en),
      .blink_en      (blink_en),
      .blank_lz      (blank_lz),
      .brightness    (brightness),
      .seg           (seg),
      .dp            (dp),
      .display_digit (display_digit),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [3:0] exp_an(input int slot);
      return ~(4'(1) << slot);
   endfunction

   function automatic logic [6:0] exp_seg(input logic [15:0] code, input int slot);
      logic [3:0] nib;
      nib = code[slot*4 +: 4];
      return seg_tb[nib];
   endfunction

   task automatic test_reset();
      digit_code = 16'h12AF; dp_en = 4'hF; blink_en = 4'h0; blank_lz = 1'b0; brightness = 4'hF;
      rst = 1'b1;
      tick();
      checks++; if (display_digit !== 4'hF) begin errors++; $display("FAIL reset_anode got %b exp 1111", display_digit); end
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
      rst = 1'b0;
   endtask

   task automatic test_scan();
      int slot;
      digit_code = 16'h12AF; dp_en = 4'h0; blink_en = 4'h0; blank_lz = 1'b0; brightness = 4'hF;
      do_reset();
      for (int k = 1; k <= 33; k++) begin
         tick();
         slot = ((k - 1) / 4) % 4;
         checks++; if (display_digit !== exp_an(slot)) begin errors++; $display("FAIL scan_anode k=%0d got %b exp %b", k, display_digit, exp_an(slot)); end
         checks++; if (seg !== exp_seg(16'h12AF, slot)) begin errors++; $display("FAIL scan_seg k=%0d got %h exp %h", k, seg, exp_seg(16'h12AF, slot)); end
         checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp k=%0d got %b exp 1", k, dp); end
         checks++; if (frame_done !== 1'(k == 17 || k == 33)) begin errors++; $display("FAIL scan_frame_done k=%0d got %b exp %b", k, frame_done, (k == 17 || k == 33)); end
      end
   endtask

   task automatic test_blanking();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      int slot;
      exp_a = '{7'h01, 7'h0F, 7'h7F, 7'h7F};
      exp_b = '{7'h01, 7'h7F, 7'h7F, 7'h7F};
      digit_code = 16'h0070; dp_en = 4'h0; blink_en = 4'h0; blank_lz = 1'b1; brightness = 4'hF;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick();
         slot = (k - 1) / 4;
         checks++; if (seg !== exp_a[slot]) begin errors++; $display("FAIL lz_0070_seg k=%0d got %h exp %h", k, seg, exp_a[slot]); end
         checks++; if (display_digit !== exp_an(slot)) begin errors++; $display("FAIL lz_0070_anode k=%0d got %b exp %b", k, display_digit, exp_an(slot)); end
      end
      digit_code = 16'h0000;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick();
         slot = (k - 1) / 4;
         checks++; if (seg !== exp_b[slot]) begin errors++; $display("FAIL lz_0000_seg k=%0d got %h exp %h", k, seg, exp_b[slot]); end
      end
   endtask

   task automatic test_snapshot();
      digit_code = 16'h1111; dp_en = 4'h0; blink_en = 4'h0; blank_lz = 1'b0; brightness = 4'hF;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 6) digit_code = 16'h2222;
         checks++; if (seg !== ((k <= 16) ? 7'h4F : 7'h12)) begin errors++; $display("FAIL snap_seg k=%0d got %h exp %h", k, seg, (k <= 16) ? 7'h4F : 7'h12); end
         checks++; if (frame_done !== 1'(k == 17)) begin errors++; $display("FAIL snap_frame_done k=%0d got %b exp %b", k, frame_done, (k == 17)); end
      end
   endtask

   task automatic test_pwm();
      int lit;
      logic on;
      int slot;
      digit_code = 16'h12AF; dp_en = 4'h0; blink_en = 4'h0; blank_lz = 1'b0; brightness = 4'd4;
      do_reset();
      lit = 0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         slot = ((k - 1) / 4) % 4;
         on = (((k - 1) % 16) < 4);
         if (k <= 16 && display_digit !== 4'hF) lit++;
         checks++; if (display_digit !== (on ? exp_an(slot) : 4'hF)) begin errors++; $display("FAIL pwm4_anode k=%0d got %b exp %b", k, display_digit, on ? exp_an(slot) : 4'hF); end
      end
      checks++; if (lit !== 4) begin errors++; $display("FAIL pwm4_lit_count got %0d exp 4", lit); end
      brightness = 4'd0;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++; if (display_digit !== 4'hF || seg !== 7'h7F) begin errors++; $display("FAIL pwm0_dark k=%0d got %b/%h exp 1111/7f", k, display_digit, seg); end
      end
   endtask

   task automatic test_blink_dp();
      int slot;
      int phase;
      logic dark;
      digit_code = 16'h12AF; dp_en = 4'b0010; blink_en = 4'b0001; blank_lz = 1'b0; brightness = 4'hF;
      do_reset();
      for (int k = 1; k <= 192; k++) begin
         tick();
         slot  = ((k - 1) / 4) % 4;
         phase = ((k - 1) / 64) % 2;
         dark  = (slot == 0) && (phase == 1);
         checks++; if (display_digit !== (dark ? 4'hF : exp_an(slot))) begin errors++; $display("FAIL blink_anode k=%0d got %b exp %b", k, display_digit, dark ? 4'hF : exp_an(slot)); end
         checks++; if (dp !== 1'(slot != 1)) begin errors++; $display("FAIL blink_dp k=%0d got %b exp %b", k, dp, (slot != 1)); end
      end
   endtask

   task automatic test_mid_reset();
      digit_code = 16'h12AF; dp_en = 4'hF; blink_en = 4'h0; blank_lz = 1'b0; brightness = 4'hF;
      do_reset();
      for (int k = 1; k <= 6; k++) tick();
      rst = 1'b1;
      tick();
      checks++; if (display_digit !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL midrst_outputs got %b/%h/%b exp 1111/7f/1", display_digit, seg, dp); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_frame_done got %b exp 0", frame_done); end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++; if (display_digit !== exp_an((k - 1) / 4)) begin errors++; $display("FAIL midrst_anode k=%0d got %b exp %b", k, display_digit, exp_an((k - 1) / 4)); end
      end
   endtask

   initial begin
      rst = 1'b1;
      digit_code = '0; dp_en = '0; blink_en = '0; blank_lz = 1'b0; brightness = '1;
      test_reset();
      test_scan();
      test_blanking();
      test_snapshot();
      test_pwm();
      test_blink_dp();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
